// File: rtl/spi_input_if.sv
// SPI slave bus: master-driven serial pins plus the byte/pixel stream produced by spi_input.
interface spi_input_if #(
  parameter int ADDR_BITS = 10
);
  logic                 SCK;
  logic                 SS;
  logic                 MOSI;
  logic [7:0]           SPI_in;
  logic                 shift_SPI;
  logic                 cost_request;
  logic [7:0]           pixel_data;
  logic [ADDR_BITS-1:0] pixel_addr;
  logic                 pixel_write;
  logic                 image_done;
  logic                 frame_error;

  modport master (
    output SCK, SS, MOSI,
    input  SPI_in, shift_SPI, cost_request, pixel_data, pixel_addr,
           pixel_write, image_done, frame_error
  );

  modport slave (
    input  SCK, SS, MOSI,
    output SPI_in, shift_SPI, cost_request, pixel_data, pixel_addr,
           pixel_write, image_done, frame_error
  );
endinterface

// File: rtl/spi_input.sv
// Mode-0 SPI slave that decodes a command byte per frame and streams image pixels
// into a write port; SPI pins are oversampled by clk (>= 4x SCK).
module spi_input #(
  parameter int NUM_PIXELS = 784,
  parameter int ADDR_BITS  = 10
) (
  input  logic        clk,
  input  logic        n_rst,
  spi_input_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CMD, PIXELS, DISCARD} state_t;

  localparam logic [7:0]           CMD_COST   = 8'h01;
  localparam logic [7:0]           CMD_IMAGE  = 8'h02;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(NUM_PIXELS - 1);

  logic [2:0]           sck_sync_reg;
  logic [1:0]           ss_sync_reg;
  logic [1:0]           mosi_sync_reg;
  logic [1:0]           warm_reg;
  logic                 armed_reg;
  state_t               state_reg;
  logic [2:0]           bit_cnt_reg;
  logic [6:0]           shift_reg;
  logic [ADDR_BITS-1:0] pix_cnt_reg;
  logic [7:0]           spi_in_reg;
  logic                 shift_spi_reg;
  logic                 cost_request_reg;
  logic [7:0]           pixel_data_reg;
  logic [ADDR_BITS-1:0] pixel_addr_reg;
  logic                 pixel_write_reg;
  logic                 image_done_reg;
  logic                 frame_error_reg;

  logic       sck_rise;
  logic       ss_s;
  logic       mosi_s;
  logic [7:0] byte_next;

  assign sck_rise  = sck_sync_reg[1] & ~sck_sync_reg[2];
  assign ss_s      = ss_sync_reg[1];
  assign mosi_s    = mosi_sync_reg[1];
  // The eighth bit goes straight into SPI_in, so only seven bits need holding.
  assign byte_next = {shift_reg, mosi_s};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sck_sync_reg  <= 3'b000;
      ss_sync_reg   <= 2'b11;
      mosi_sync_reg <= 2'b00;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[1:0], bus.SCK};
      ss_sync_reg   <= {ss_sync_reg[0], bus.SS};
      mosi_sync_reg <= {mosi_sync_reg[0], bus.MOSI};
    end
  end

  // A frame may only start after SS has genuinely been seen high since reset,
  // so the reset value of the synchronizer cannot fake a falling edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      warm_reg  <= 2'd0;
      armed_reg <= 1'b0;
    end else begin
      if (warm_reg != 2'd2) warm_reg <= warm_reg + 2'd1;
      if (warm_reg == 2'd2 && ss_s) armed_reg <= 1'b1;
      else if (!ss_s)               armed_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg        <= IDLE;
      bit_cnt_reg      <= 3'd0;
      shift_reg        <= 7'd0;
      pix_cnt_reg      <= '0;
      spi_in_reg       <= 8'h00;
      shift_spi_reg    <= 1'b0;
      cost_request_reg <= 1'b0;
      pixel_data_reg   <= 8'h00;
      pixel_addr_reg   <= '0;
      pixel_write_reg  <= 1'b0;
      image_done_reg   <= 1'b0;
      frame_error_reg  <= 1'b0;
    end else begin
      shift_spi_reg    <= 1'b0;
      cost_request_reg <= 1'b0;
      pixel_write_reg  <= 1'b0;
      image_done_reg   <= 1'b0;
      frame_error_reg  <= 1'b0;

      if (ss_s) begin
        // Deselect has priority over any coincident SCK edge.
        if (state_reg != IDLE && bit_cnt_reg != 3'd0) frame_error_reg <= 1'b1;
        state_reg   <= IDLE;
        bit_cnt_reg <= 3'd0;
        shift_reg   <= 7'd0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (armed_reg) begin
              state_reg   <= CMD;
              bit_cnt_reg <= 3'd0;
              shift_reg   <= 7'd0;
            end
          end
          default: begin
            if (sck_rise) begin
              shift_reg   <= byte_next[6:0];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                spi_in_reg    <= byte_next;
                shift_spi_reg <= 1'b1;
                case (state_reg)
                  CMD: begin
                    if (byte_next == CMD_COST) begin
                      cost_request_reg <= 1'b1;
                      state_reg        <= DISCARD;
                    end else if (byte_next == CMD_IMAGE) begin
                      pix_cnt_reg <= '0;
                      state_reg   <= PIXELS;
                    end else begin
                      state_reg <= DISCARD;
                    end
                  end
                  PIXELS: begin
                    pixel_write_reg <= 1'b1;
                    pixel_data_reg  <= byte_next;
                    pixel_addr_reg  <= pix_cnt_reg;
                    pix_cnt_reg     <= pix_cnt_reg + ADDR_BITS'(1);
                    if (pix_cnt_reg == LAST_ADDR) begin
                      image_done_reg <= 1'b1;
                      state_reg      <= DISCARD;
                    end
                  end
                  default: ;
                endcase
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.SPI_in       = spi_in_reg;
  assign bus.shift_SPI    = shift_spi_reg;
  assign bus.cost_request = cost_request_reg;
  assign bus.pixel_data   = pixel_data_reg;
  assign bus.pixel_addr   = pixel_addr_reg;
  assign bus.pixel_write  = pixel_write_reg;
  assign bus.image_done   = image_done_reg;
  assign bus.frame_error  = frame_error_reg;

endmodule

// File: doc/spi_input.md
SPI_INPUT -- requirements
Module: spi_input

Interface
REQ-001 Parameter: NUM_PIXELS, 784, number of pixel bytes in one image load (28x28).
REQ-002 Parameter: ADDR_BITS, 10, width of pixel_addr; SHALL satisfy 2^ADDR_BITS >= NUM_PIXELS.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SCK  input  1  SPI serial clock from master, asynchronous to clk.
REQ-006 SS  input  1  slave select from master, active-low, asynchronous to clk.
REQ-007 MOSI  input  1  serial data from master, asynchronous to clk, MSB first.
REQ-008 SPI_in  output  8  last complete received byte.
REQ-009 shift_SPI  output  1  one-cycle pulse, SPI_in updated this cycle.
REQ-010 cost_request  output  1  one-cycle pulse, command 0x01 received.
REQ-011 pixel_data  output  8  pixel byte being written.
REQ-012 pixel_addr  output  ADDR_BITS  address of pixel byte being written.
REQ-013 pixel_write  output  1  one-cycle write strobe for pixel_data/pixel_addr.
REQ-014 image_done  output  1  one-cycle pulse, last pixel (NUM_PIXELS-1) written.
REQ-015 frame_error  output  1  one-cycle pulse, SS deasserted with partial byte.

Function
REQ-016 SCK, SS, MOSI SHALL each pass through a 2-flop synchronizer; SCK SHALL have a third history flop for edge detection.
REQ-017 SPI mode 0: a bit SHALL be sampled only on a synchronized SCK rising edge (stage2=1, stage3=0) while synchronized SS=0.
REQ-018 Sampled bits SHALL shift into an 8-bit register MSB first; a 3-bit counter SHALL count bits 0..7.
REQ-019 On the 8th bit edge (cycle N), SPI_in SHALL take the full byte and shift_SPI SHALL pulse in cycle N+1; counter SHALL wrap to 0.
REQ-020 clk frequency SHALL be >= 4x SCK frequency; behaviour below this is undefined.
REQ-021 FSM states: IDLE, CMD, PIXELS, DISCARD.
REQ-022 IDLE: on synchronized SS falling, go to CMD; bit counter cleared.
REQ-023 CMD: first byte of frame is command; 0x01 -> cost_request pulse with shift_SPI, go to DISCARD; 0x02 -> pixel address counter cleared to 0, go to PIXELS; other -> DISCARD.
REQ-024 PIXELS: each byte -> pixel_write pulse with shift_SPI, pixel_data=byte, pixel_addr=current count; count then increments.
REQ-025 Write at address NUM_PIXELS-1 SHALL pulse image_done same cycle and go to DISCARD; no further pixel_write in that frame.
REQ-026 DISCARD: bytes still produce SPI_in/shift_SPI but no cost_request/pixel_write.
REQ-027 Any state: synchronized SS=1 SHALL return to IDLE, clear bit counter, discard partial byte.
REQ-028 SS rising with bit counter != 0 SHALL pulse frame_error once; with counter=0 no pulse.
REQ-029 SS rise and SCK rising edge detected same cycle: SS wins; edge ignored.
REQ-030 Frame ending in PIXELS before NUM_PIXELS bytes: no image_done; next 0x02 command restarts at address 0.
REQ-031 pixel_data and pixel_addr SHALL hold value between writes.

Reset
REQ-032 n_rst low SHALL asynchronously force: state IDLE, synchronizers to SCK=0/SS=1/MOSI=0, bit counter 0, shift register 0, pixel count 0.
REQ-033 Reset values: SPI_in=0x00, shift_SPI=0, cost_request=0, pixel_data=0x00, pixel_addr=0, pixel_write=0, image_done=0, frame_error=0.
REQ-034 Reset mid-frame SHALL discard the partial byte and frame; after release, a new SS falling edge is required before reception.

Verification
REQ-035 SS low, send 0xA5, SS high -> one shift_SPI pulse, SPI_in=0xA5, no cost_request, no frame_error.
REQ-036 Frame 0x01 -> SPI_in=0x01, shift_SPI and cost_request pulse same cycle, exactly once.
REQ-037 Frame 0x02 then 784 bytes value addr[7:0] -> 784 pixel_write pulses, addr 0..783 in order, image_done with addr 783; 785th byte gives shift_SPI only.
REQ-038 Frame 0x02, 3 bytes, SS high after 5 bits of 4th -> 3 writes (addr 0..2), one frame_error, no image_done; next 0x02 frame starts at addr 0.
REQ-039 Assert n_rst mid-byte in PIXELS -> all outputs at reset values immediately; next frame 0x01 gives cost_request normally.
REQ-040 SCK at clk/4 with random MOSI, 100 bytes in DISCARD -> every SPI_in matches transmitted byte, latency one cycle after 8th detected edge.
